charge_gatherer: RTL and testbench
==================================

# charge_gatherer

- Downstream neighbour of the particle scatterer.
- Once scattering finishes (the scatterer's `done`), it sweeps the banked charge grid, issuing paired quad read requests on the scatterer's solve-step port.
- The scatterer replies after a fixed latency with no return valid; this block realigns each reply with a delay line, buffers it in a credit-guarded FIFO, and streams one quad (four bank charges) per handshake to the field solver.

## Interface

Parameters:
- `LATENCY`, 8, cycles from `valid_req` high to the matching `charge_in` being valid.
- `FIFO_DEPTH`, 16, quad entries; even, ≥ 4.
- `NUM_QUADS`, `defs::NUM_QUADS`, 2×2 grid blocks; = GRID_X·GRID_Y/4, even.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a sweep; driven from scatterer `done`.
- `valid_req`  out  1  request strobe to scatterer.
- `grid_addr_out`  out  `addr_t [3:0] [1:0]`  bank addresses; group 0 = quad 2n, group 1 = quad 2n+1.
- `charge_in`  in  `charge_t [3:0] [1:0]`  scatterer reply; group g matches `grid_addr_out` group g.
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  solver accepts beat.
- `m_charge`  out  `charge_t [3:0]`  charges of one quad, bank b = {y[0],x[0]}.
- `m_quad`  out  `addr_t`  quad index of the beat.
- `m_last`  out  1  beat is quad NUM_QUADS−1.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse after the last beat is accepted.

## Operation

- Banking: a grid point (y,x) lives in bank {y[0],x[0]} at address {y>>1, x>>1} = quad index. Every bank address in quad k equals k, so `grid_addr_out[g][b] = 2n+g` for all b.
- FSM states: IDLE, SWEEP, DRAIN.
  - IDLE: `start` → SWEEP, clear request counter n.
  - SWEEP: issue a request when credit allows. On issuing n = NUM_QUADS/2−1 → DRAIN.
  - DRAIN: wait for in-flight replies to land and the FIFO to empty. On acceptance of the `m_last` beat → IDLE with a `done` pulse.
- `start` is ignored outside IDLE.
- Credit rule: issue only if occupancy + inflight_quads + 2 ≤ FIFO_DEPTH, using registered values (a same-cycle pop is not credited). inflight_quads counts +2 per issue and −2 per capture.
- Return alignment: a LATENCY-deep shift register of `valid_req`. When its tap is high, both groups are written into the FIFO in group order (two writes in one cycle). Overflow is impossible by the credit rule; the bench asserts this.
- FIFO: show-ahead; head is registered onto `m_charge`, `m_quad`, `m_last`.
- Output handshake: pop on `m_valid && m_ready`. Data is held stable while `m_valid && !m_ready`.
- `m_quad` is carried in the FIFO alongside the charge. Order is strictly increasing 0…NUM_QUADS−1.
- Arithmetic:
  - `charge_t` values pass through unmodified; no saturation.
  - Counters are sized `$clog2(NUM_QUADS)+1`.
  - Occupancy and inflight counters are sized `$clog2(FIFO_DEPTH)+1`.

## Timing

- Reset values: `valid_req`, `m_valid`, `m_last`, `busy`, `done` = 0; `grid_addr_out`, `m_charge`, `m_quad` = 0. FSM = IDLE, delay line cleared, FIFO empty, counters 0.
- Reset mid-sweep: every item above returns to its reset value on the next edge. Replies still in flight are discarded because the delay line is cleared.
- Latency with `m_ready` held high:
  - `start` at cycle 0.
  - First `valid_req` at cycle 1.
  - Capture at 1+LATENCY.
  - First `m_valid` at 2+LATENCY, i.e. cycle 10 at defaults.
- Throughput: one beat per cycle sustained; requests settle to one every other cycle.
- `busy` is high from the cycle after `start` through the cycle of the last handshake.
- `done` is high exactly one cycle, the cycle after the last handshake; `busy` is low that same cycle.
- `start` coincident with `done` is accepted, since the FSM is already IDLE that cycle.

## Structure

- `defs` package:
  - `NUM_QUADS`
  - `quad_beat_t` struct {`charge_t [3:0] charge`; `addr_t quad`; `logic last`}
  - `gather_state_e`
- Sub-module `quad_fifo`: show-ahead, two-write/one-read, parameterised depth. The delay line, credit logic and FSM stay in `charge_gatherer`.

## Test plan

- Reset: hold `rst` for 3 cycles, pulse `start` during reset → all outputs 0, no `valid_req`.
- Full sweep, NUM_QUADS=64, `m_ready`=1, scatterer model LATENCY=8 returning charge = 16·quad+bank:
  - first `m_valid` at cycle 10;
  - beats 0…63 in order with matching data;
  - `m_last` only on quad 63;
  - `done` one cycle after it.
- Backpressure: `m_ready`=0 for 100 cycles after `start` → exactly 8 requests issued, occupancy peaks at 16, no overflow. Then `m_ready`=1 → remaining quads are delivered with no loss or duplication.
- Random `m_ready` (50%), 20 seeds → output matches the reference queue and `m_charge` is stable while stalled.
- `rst` at the cycle after the 5th request, with replies in flight → no beat is emitted after reset. A new `start` produces a clean sweep from quad 0.
- `start` during SWEEP is ignored (single sweep). `start` in the `done` cycle begins a second sweep.

Source files
------------

// File: rtl/charge_gatherer_pkg.sv
// defs: shared charge/address types, beat record and FSM states for the charge gatherer
package defs;
  localparam int GRID_X = 16;
  localparam int GRID_Y = 16;
  localparam int NUM_QUADS = GRID_X * GRID_Y / 4;
  typedef logic [15:0] charge_t;
  typedef logic [7:0] addr_t;
  typedef struct packed {
    charge_t [3:0] charge;
    addr_t         quad;
    logic          last;
  } quad_beat_t;
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} gather_state_e;
endpackage

// File: rtl/charge_gatherer_fifo.sv
// quad_fifo: show-ahead FIFO taking two beats per write and giving one beat per read
module quad_fifo import defs::*; #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_i,
  input  quad_beat_t [1:0]       wr_data_i,
  input  logic                   rd_i,
  output logic                   valid_o,
  output quad_beat_t             rd_data_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  quad_beat_t mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] count_q;
  logic pop;
  assign valid_o = count_q != '0;
  assign pop = rd_i && valid_o;
  assign rd_data_o = valid_o ? mem_q[rp_q] : '0;
  assign count_o = count_q;
  // pairs are always written together, so wp_q stays even and wp_q+1 never wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      count_q <= '0;
    end else begin
      if (wr_i) begin
        mem_q[wp_q] <= wr_data_i[0];
        mem_q[wp_q + AW'(1)] <= wr_data_i[1];
        wp_q <= (wp_q == AW'(DEPTH - 2)) ? '0 : wp_q + AW'(2);
      end
      if (pop) rp_q <= (rp_q == AW'(DEPTH - 1)) ? '0 : rp_q + AW'(1);
      count_q <= count_q + (wr_i ? (AW+1)'(2) : '0) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/charge_gatherer.sv
// charge_gatherer: sweeps the scatterer's banked grid and streams realigned quads to the solver
module charge_gatherer import defs::*; #(
  parameter int LATENCY    = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int NUM_QUADS  = defs::NUM_QUADS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             valid_req,
  output addr_t [3:0][1:0] grid_addr_out,
  input  charge_t [3:0][1:0] charge_in,
  output logic             m_valid,
  input  logic             m_ready,
  output charge_t [3:0]    m_charge,
  output addr_t            m_quad,
  output logic             m_last,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(NUM_QUADS) + 1;
  localparam int OW = $clog2(FIFO_DEPTH) + 1;
  gather_state_e state_q;
  logic [CW-1:0] n_q, cap_q, req_n;
  logic [OW-1:0] inflight_q, occ;
  logic [LATENCY-1:0] dl_q;
  logic tap, credit, issue, pop, last_req;
  quad_beat_t head;
  quad_beat_t [1:0] cap_beats;
  assign tap = dl_q[LATENCY-1];
  assign credit = int'(occ) + int'(inflight_q) + 2 <= FIFO_DEPTH;
  assign req_n = (state_q == IDLE) ? '0 : n_q;
  assign issue = credit && ((state_q == IDLE && start) || state_q == SWEEP);
  assign last_req = req_n == CW'(NUM_QUADS / 2 - 1);
  assign pop = m_valid && m_ready;
  assign busy = state_q != IDLE;
  assign m_charge = head.charge;
  assign m_quad = head.quad;
  assign m_last = head.last;
  // replies land in issue order, so a capture counter recovers the quad index
  always_comb begin
    cap_beats = '0;
    for (int g = 0; g < 2; g++) begin
      cap_beats[g].quad = addr_t'(2 * cap_q + g);
      cap_beats[g].last = (2 * cap_q + g) == NUM_QUADS - 1;
      for (int b = 0; b < 4; b++) cap_beats[g].charge[b] = charge_in[b][g];
    end
  end
  quad_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .wr_i(tap), .wr_data_i(cap_beats), .rd_i(pop),
    .valid_o(m_valid), .rd_data_o(head), .count_o(occ)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q <= '0;
      cap_q <= '0;
      inflight_q <= '0;
      dl_q <= '0;
      valid_req <= 1'b0;
      grid_addr_out <= '0;
      done <= 1'b0;
    end else begin
      dl_q <= LATENCY'({dl_q, valid_req});
      valid_req <= issue;
      done <= pop && m_last;
      inflight_q <= inflight_q + (issue ? OW'(2) : '0) - (tap ? OW'(2) : '0);
      cap_q <= (state_q == IDLE && start) ? '0 : cap_q + CW'(tap);
      n_q <= issue ? req_n + CW'(1) : (state_q == IDLE ? '0 : n_q);
      if (issue)
        for (int g = 0; g < 2; g++)
          for (int b = 0; b < 4; b++) grid_addr_out[b][g] <= addr_t'(2 * req_n + g);
      case (state_q)
        IDLE:    if (start) state_q <= (issue && last_req) ? DRAIN : SWEEP;
        SWEEP:   if (issue && last_req) state_q <= DRAIN;
        DRAIN:   if (pop && m_last) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_charge_gatherer.sv
// tb_charge_gatherer: scoreboard bench with a fixed-latency scatterer model
module tb_charge_gatherer;
  import defs::*;
  localparam int LAT = 8;
  localparam int DEPTH = 16;
  localparam int NQ = defs::NUM_QUADS;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic valid_req, m_valid, m_ready, m_last, busy, done;
  addr_t [3:0][1:0] grid_addr_out;
  charge_t [3:0][1:0] charge_in = '0;
  charge_t [3:0] m_charge;
  addr_t m_quad;
  int n_cmp = 0, n_err = 0, cyc = 0, start_cyc = 0, first_mv = -1, first_vr = -1;
  int reqs = 0, next_req = 0, beats = 0, done_cnt = 0, occ_m = 0, peak = 0, last_hs = -10, q;
  logic cap_p = 0, pop_p = 0, stalled = 0, hs_last = 0, rdy_mode = 0, rdy_fix = 1;
  logic [31:0] lfsr = 32'hACE1;
  logic [72:0] held;
  logic hv_v [LAT+1];
  addr_t [3:0][1:0] hv_a [LAT+1];
  quad_beat_t exp_q[$];
  quad_beat_t e;

  charge_gatherer #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .NUM_QUADS(NQ)) dut (
    .clk(clk), .rst(rst), .start(start), .valid_req(valid_req), .grid_addr_out(grid_addr_out),
    .charge_in(charge_in), .m_valid(m_valid), .m_ready(m_ready), .m_charge(m_charge),
    .m_quad(m_quad), .m_last(m_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      lfsr = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
      m_ready = rdy_mode ? lfsr[0] : rdy_fix;
    end
  end

  // scatterer model, occupancy model and scoreboard
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      occ_m = 0; cap_p = 0; pop_p = 0; stalled = 0; next_req = 0;
      for (int i = 0; i <= LAT; i++) begin hv_v[i] = 1'b0; hv_a[i] = '0; end
    end else begin
      occ_m += 2 * int'(cap_p) - int'(pop_p);
      if (occ_m > peak) peak = occ_m;
      if (occ_m > DEPTH) chk("overflow", occ_m, DEPTH);
      chk("m_valid", m_valid, occ_m != 0);
      if (valid_req) begin
        reqs++;
        if (first_vr < 0) first_vr = cyc;
        for (int g = 0; g < 2; g++) begin
          q = 2 * next_req + g;
          for (int b = 0; b < 4; b++) begin
            chk("addr", grid_addr_out[b][g], q);
            e.charge[b] = charge_t'(16 * q + b);
          end
          e.quad = addr_t'(q);
          e.last = q == NQ - 1;
          exp_q.push_back(e);
        end
        next_req++;
      end
      for (int i = LAT; i > 0; i--) begin hv_v[i] = hv_v[i-1]; hv_a[i] = hv_a[i-1]; end
      hv_v[0] = valid_req;
      hv_a[0] = grid_addr_out;
      cap_p = hv_v[LAT];
      for (int g = 0; g < 2; g++)
        for (int b = 0; b < 4; b++)
          charge_in[b][g] = cap_p ? charge_t'(16 * int'(hv_a[LAT][b][g]) + b) : charge_t'($urandom);
      if (stalled) chk("hold", {m_valid, m_charge, m_quad, m_last}, {1'b1, held});
      pop_p = m_valid && m_ready;
      stalled = m_valid && !m_ready;
      held = {m_charge, m_quad, m_last};
      if (m_valid && first_mv < 0) first_mv = cyc;
      if (pop_p) begin
        beats++;
        chk("busy_hs", busy, 1);
        if (exp_q.size() == 0) chk("spurious_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("beat", {m_charge, m_quad, m_last}, e);
        end
        if (m_last) begin last_hs = cyc; hs_last = 1'b1; end
      end
      if (done || cyc == last_hs + 1) chk("done", done, cyc == last_hs + 1);
      if (done) begin
        chk("done_busy", busy, 0);
        done_cnt++;
      end
    end
  end

  task automatic fresh_stats();
    start_cyc = cyc; first_mv = -1; first_vr = -1; reqs = 0; next_req = 0; beats = 0; peak = 0;
  endtask

  task automatic pulse_start(input bit fresh);
    @(posedge clk);
    #1;
    start = 1'b1;
    if (fresh) fresh_stats();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0, k;
    d0 = done_cnt;
    for (k = 0; k < budget; k++) begin
      @(posedge clk);
      if (done_cnt != d0) break;
    end
    if (k == budget) chk("done_timeout", 0, 1);
  endtask

  task automatic sweep_end(input string tag);
    chk({tag, "_beats"}, beats, NQ);
    chk({tag, "_qempty"}, exp_q.size(), 0);
  endtask

  initial begin
    int k, dd, b0;
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, dd, b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      start = (i == 1);
    end
    @(negedge clk);
    chk("rst_valid_req", valid_req, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", grid_addr_out, 0);
    chk("rst_charge", m_charge, 0);
    chk("rst_quad", m_quad, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_valid_req", valid_req, 0);
      chk("idle_busy", busy, 0);
    end
    // full sweep, ready held high
    pulse_start(1);
    wait_done(300);
    chk("lat_valid_req", first_vr - start_cyc, 1);
    chk("lat_m_valid", first_mv - start_cyc, 10);
    sweep_end("full");
    // backpressure
    rdy_fix = 1'b0;
    pulse_start(1);
    repeat (100) @(posedge clk);
    chk("bp_reqs", reqs, 8);
    chk("bp_peak", peak, DEPTH);
    chk("bp_beats", beats, 0);
    rdy_fix = 1'b1;
    wait_done(300);
    sweep_end("bp");
    // random ready
    for (int s = 0; s < 20; s++) begin
      lfsr = 32'hACE1 + s * 32'h0001_0001;
      rdy_mode = 1'b1;
      pulse_start(1);
      wait_done(2000);
      rdy_mode = 1'b0;
      sweep_end("rnd");
    end
    // reset with replies in flight
    pulse_start(1);
    for (k = 0; k < 50; k++) begin
      @(posedge clk);
      if (reqs >= 5) break;
    end
    if (k == 50) chk("req5_timeout", 0, 1);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    b0 = beats;
    repeat (30) @(posedge clk);
    chk("post_rst_beats", beats - b0, 0);
    chk("post_rst_busy", busy, 0);
    pulse_start(1);
    wait_done(300);
    sweep_end("after_rst");
    // start during SWEEP is ignored
    pulse_start(1);
    repeat (5) @(posedge clk);
    pulse_start(0);
    dd = done_cnt;
    wait_done(300);
    repeat (20) @(posedge clk);
    chk("single_done", done_cnt - dd, 1);
    chk("single_reqs", reqs, NQ / 2);
    sweep_end("single");
    // start coincident with done
    hs_last = 1'b0;
    pulse_start(1);
    for (k = 0; k < 300; k++) begin
      @(posedge clk);
      if (hs_last) break;
    end
    if (k == 300) chk("last_hs_timeout", 0, 1);
    sweep_end("first_of_two");
    #1;
    start = 1'b1;
    dd = done_cnt;
    fresh_stats();
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("done_with_start", done_cnt - dd, 1);
    wait_done(300);
    sweep_end("second_of_two");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
